// File: rtl/lcd1602_pkg.sv
// rtl/lcd1602_pkg.sv - LCD1602 responder opcodes, DDRAM geometry and address-counter helpers
package lcd1602_pkg;

  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  localparam logic [6:0] ROW1_BASE  = 7'h00;
  localparam logic [6:0] ROW2_BASE  = 7'h40;
  localparam logic [6:0] ROW_END    = 7'h27;
  localparam logic [6:0] ROW2_END   = ROW2_BASE + ROW_END;
  localparam int         VIS_COLS   = 16;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam int         NUM_CELLS  = 2 * VIS_COLS;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // Row ends jump to the other row; any other address (including out-of-range
  // values written by set-DDRAM) just moves by one modulo 128.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == ROW_END)       nxt = ROW2_BASE;
      else if (ac == ROW2_END) nxt = ROW1_BASE;
      else                     nxt = ac + 7'd1;
    end else begin
      if (ac == ROW1_BASE)      nxt = ROW2_END;
      else if (ac == ROW2_BASE) nxt = ROW_END;
      else                      nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  function automatic logic ac_visible(input logic [6:0] ac);
    return int'(ac[5:0]) < VIS_COLS;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// rtl/lcd_bus_sync.sv - synchronises the LCD bus and strobes a filtered lcd_en falling edge
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       fall,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);

  localparam int CW = $clog2(MIN_EN_HIGH + 1);

  // Index 0 is the newest sample; the extra stage past SYNC_STAGES holds the
  // last sample taken while lcd_en was still high when the fall is seen.
  logic [SYNC_STAGES:0][10:0] pipe;
  logic [CW-1:0]              high_cnt;
  logic                       en_s, en_d;

  assign en_s = pipe[SYNC_STAGES-1][10];
  assign en_d = pipe[SYNC_STAGES][10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe     <= '0;
      high_cnt <= '0;
    end else begin
      pipe <= {pipe[SYNC_STAGES-1:0], {lcd_en, lcd_rs, lcd_rw, lcd_data}};
      if (!en_s)
        high_cnt <= '0;
      else if (high_cnt != CW'(MIN_EN_HIGH))
        high_cnt <= high_cnt + 1'b1;
    end
  end

  assign fall = en_d & ~en_s & (high_cnt == CW'(MIN_EN_HIGH));
  assign rs   = pipe[SYNC_STAGES][9];
  assign rw   = pipe[SYNC_STAGES][8];
  assign data = pipe[SYNC_STAGES][7:0];

endmodule

// File: rtl/lcd_1602_rx.sv
// rtl/lcd_1602_rx.sv - HD44780 write-bus responder mirroring visible characters into a 2x16 buffer
module lcd_1602_rx
  import lcd1602_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rw,
  input  logic       lcd_rs,
  input  logic [7:0] lcd_data,
  output logic       cell_we,
  output logic [4:0] cell_addr,
  output logic [7:0] cell_char,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       two_line,
  output logic       busy,
  output logic       cmd_err
);

  logic       bus_fall, bus_rs, bus_rw;
  logic [7:0] bus_data;
  state_t     state;
  logic [4:0] sweep_cnt;
  logic       inc_mode;

  lcd_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_EN_HIGH(MIN_EN_HIGH)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .lcd_en  (lcd_en),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_data(lcd_data),
    .fall    (bus_fall),
    .rs      (bus_rs),
    .rw      (bus_rw),
    .data    (bus_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sweep_cnt <= '0;
      inc_mode  <= 1'b1;
      cell_we   <= 1'b0;
      cell_addr <= '0;
      cell_char <= '0;
      addr_cnt  <= '0;
      disp_on   <= 1'b0;
      two_line  <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cell_we <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cell_we   <= 1'b1;
          cell_addr <= sweep_cnt;
          cell_char <= CHAR_SPACE;
          sweep_cnt <= sweep_cnt + 5'd1;
          if (sweep_cnt == 5'(NUM_CELLS - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          // The sweep cannot be interrupted, so anything arriving now is lost.
          if (bus_fall)
            cmd_err <= 1'b1;
        end
        default: begin
          if (bus_fall) begin
            if (bus_rw) begin
              cmd_err <= 1'b1;
            end else if (bus_rs) begin
              if (ac_visible(addr_cnt)) begin
                cell_we   <= 1'b1;
                cell_addr <= {addr_cnt[6], addr_cnt[3:0]};
                cell_char <= bus_data;
              end
              addr_cnt <= ac_step(addr_cnt, inc_mode);
            end else if (|(bus_data & OP_SET_DDRAM)) begin
              addr_cnt <= bus_data[6:0];
            end else if (|(bus_data & OP_SET_CGRAM)) begin
            end else if (|(bus_data & OP_FUNC_SET)) begin
              two_line <= bus_data[3];
            end else if (|(bus_data & OP_SHIFT)) begin
              if (bus_data[3])
                cmd_err <= 1'b1;
              else
                addr_cnt <= ac_step(addr_cnt, bus_data[2]);
            end else if (|(bus_data & OP_DISP_CTRL)) begin
              disp_on <= bus_data[2];
            end else if (|(bus_data & OP_ENTRY)) begin
              inc_mode <= bus_data[1];
            end else if (|(bus_data & OP_HOME)) begin
              addr_cnt <= '0;
            end else if (|(bus_data & OP_CLEAR)) begin
              state     <= ST_CLEAR;
              busy      <= 1'b1;
              sweep_cnt <= '0;
              inc_mode  <= 1'b1;
              addr_cnt  <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_1602_rx.sv
// tb/tb_lcd_1602_rx.sv - scoreboard bench for lcd_1602_rx against a DDRAM reference model
module tb_lcd_1602_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_en = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_rs = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       cell_we;
  logic [4:0] cell_addr;
  logic [7:0] cell_char;
  logic [6:0] addr_cnt;
  logic       disp_on, two_line, busy, cmd_err;

  always #5 clk = ~clk;

  lcd_1602_rx dut (
    .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs),
    .lcd_data(lcd_data), .cell_we(cell_we), .cell_addr(cell_addr), .cell_char(cell_char),
    .addr_cnt(addr_cnt), .disp_on(disp_on), .two_line(two_line), .busy(busy), .cmd_err(cmd_err)
  );

  typedef struct { int addr; int ch; } cell_t;
  cell_t exp_q[$];

  int checks = 0, errors = 0;
  int m_ac = 0, m_inc = 1, m_disp = 0, m_two = 0;
  int err_exp = 0, err_seen = 0, busy_cycles = 0;
  bit ignore_cells = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cell write must match the next expected one in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cell_we && !ignore_cells) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cell_unexpected: got addr %0d char %0h expected none", cell_addr, cell_char);
        end else begin
          cell_t e;
          e = exp_q.pop_front();
          if (int'(cell_addr) != e.addr || int'(cell_char) != e.ch) begin
            errors++;
            $display("FAIL cell_write: got addr %0d char %0h expected addr %0d char %0h",
                     cell_addr, cell_char, e.addr, e.ch);
          end
        end
      end
      if (cmd_err) err_seen++;
      if (busy) busy_cycles++;
    end
  end

  // DDRAM is two 40-byte rows at 0x00 and 0x40; stepping past a row end lands on the other row.
  function automatic int next_ac(input int ac, input int inc);
    if (inc != 0) begin
      if (ac == 39) return 64;
      if (ac == 103) return 0;
      return (ac + 1) % 128;
    end
    if (ac == 0) return 103;
    if (ac == 64) return 39;
    return (ac + 127) % 128;
  endfunction

  task automatic model(input bit rs, input bit rw, input int d);
    if (rw) err_exp++;
    else if (rs) begin
      if (m_ac < 16) exp_q.push_back('{m_ac, d});
      else if (m_ac >= 64 && m_ac < 80) exp_q.push_back('{m_ac - 48, d});
      m_ac = next_ac(m_ac, m_inc);
    end
    else if (d >= 128) m_ac = d - 128;
    else if (d >= 64) ;
    else if (d >= 32) m_two = (d >> 3) & 1;
    else if (d >= 16) begin
      if ((d & 8) != 0) err_exp++;
      else m_ac = next_ac(m_ac, (d >> 2) & 1);
    end
    else if (d >= 8) m_disp = (d >> 2) & 1;
    else if (d >= 4) m_inc = (d >> 1) & 1;
    else if (d >= 2) m_ac = 0;
    else if (d == 1) begin
      for (int i = 0; i < 32; i++) exp_q.push_back('{i, 32});
      m_inc = 1;
      m_ac = 0;
    end
  endtask

  task automatic bus(input bit rs, input bit rw, input logic [7:0] d, input int hi);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    #2 lcd_en = 1'b1;
    repeat (hi) @(negedge clk);
    #2 lcd_en = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":addr_cnt"}, addr_cnt, m_ac);
    chk({tag, ":disp_on"}, disp_on, m_disp);
    chk({tag, ":two_line"}, two_line, m_two);
    chk({tag, ":cmd_err_count"}, err_seen, err_exp);
    chk({tag, ":pending_cells"}, exp_q.size(), 0);
  endtask

  task automatic xfer(input bit rs, input bit rw, input logic [7:0] d);
    model(rs, rw, int'(d));
    bus(rs, rw, d, 8);
    repeat ((!rs && !rw && d == 8'h01) ? 45 : 12) @(negedge clk);
  endtask

  logic [7:0] init_seq [5] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic [7:0] volt [8] = '{8'h56, 8'h6F, 8'h6C, 8'h74, 8'h61, 8'h67, 8'h65, 8'h3A};

  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset:cell_we", cell_we, 0);
    chk("reset:cmd_err", cmd_err, 0);
    chk("reset:busy", busy, 0);
    check_state("reset");

    for (int i = 0; i < 5; i++) begin
      if (init_seq[i] == 8'h01) busy_cycles = 0;
      xfer(0, 0, init_seq[i]);
      if (init_seq[i] == 8'h01) chk("init:busy_cycles", busy_cycles, 32);
    end
    check_state("init");

    xfer(0, 0, 8'h80);
    for (int i = 0; i < 8; i++) xfer(1, 0, volt[i]);
    check_state("voltage");

    xfer(0, 0, 8'hC0);
    for (int i = 0; i < 17; i++) xfer(1, 0, 8'($urandom_range(32, 126)));
    check_state("row2_fill");

    xfer(0, 0, 8'hA7);
    xfer(1, 0, 8'h41);
    chk("wrap27:addr_cnt", addr_cnt, 8'h40);
    xfer(1, 0, 8'h42);
    check_state("wrap27");

    xfer(0, 0, 8'h04);
    xfer(0, 0, 8'h80);
    xfer(1, 0, 8'h58);
    chk("dec_wrap:addr_cnt", addr_cnt, 8'h67);

    // Glitch and a too-short enable pulse must both be filtered out.
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h21;
    #3 lcd_en = 1'b1;
    #3 lcd_en = 1'b0;
    repeat (12) @(negedge clk);
    bus(1, 0, 8'h22, 2);
    repeat (12) @(negedge clk);
    check_state("glitch");

    xfer(0, 0, 8'h06);
    xfer(0, 0, 8'h14);
    xfer(0, 0, 8'h10);
    xfer(0, 0, 8'h18);
    xfer(0, 0, 8'h4A);
    xfer(1, 1, 8'h00);
    xfer(0, 0, 8'h00);
    xfer(0, 0, 8'h02);
    check_state("misc");

    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r < 6)       xfer(1, 0, 8'($urandom_range(32, 126)));
      else if (r == 6) xfer(0, 0, 8'(8'h80 | $urandom_range(0, 127)));
      else if (r == 7) xfer(0, 0, 8'(8'h10 | ($urandom_range(0, 1) << 2) | ($urandom_range(0, 5) == 0 ? 8 : 0)));
      else if (r == 8) xfer(0, 0, 8'(8'h04 | ($urandom_range(0, 1) << 1) | $urandom_range(0, 1)));
      else if (r == 9) xfer(0, 0, 8'(8'h08 | ($urandom_range(0, 7))));
      else if (r == 10) xfer(0, 0, 8'(8'h20 | ($urandom_range(0, 31))));
      else             xfer(1, 1, 8'($urandom));
    end
    check_state("random");

    // Data arriving during the clear sweep is dropped with an error.
    model(0, 0, 1);
    bus(0, 0, 8'h01, 8);
    repeat (3) @(negedge clk);
    err_exp++;
    bus(1, 0, 8'h31, 6);
    repeat (45) @(negedge clk);
    check_state("drop_in_clear");

    ignore_cells = 1;
    bus(0, 0, 8'h01, 8);
    repeat (10) @(negedge clk);
    chk("midsweep:busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midsweep:busy_after", busy, 0);
    chk("midsweep:cell_we", cell_we, 0);
    exp_q.delete();
    m_ac = 0; m_inc = 1; m_disp = 0; m_two = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midsweep:busy_idle", busy, 0);
    ignore_cells = 0;
    xfer(1, 0, 8'h5A);
    check_state("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
